// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: RV32M multiply funct3 encodings and the
// multiplier FSM state type (also visible to the EX controller for debug).
package tinyriscv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        END  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes, fixes the sign at the end; fixed WIDTH+2 cycle latency.
module mul_iter
    import tinyriscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t       state_reg,  state_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic [2:0]       op_reg,     op_next;
    logic             neg_reg,    neg_next;
    logic [WIDTH-1:0] mcand_reg,  mcand_next;
    logic [WIDTH-1:0] acc_hi_reg, acc_hi_next;
    // Low half of the accumulator: product bits shift in from the top as
    // multiplier bits are consumed from the bottom.
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] data_reg,   data_next;
    logic             ready_reg,  ready_next;

    logic             rs1_signed, rs2_signed;
    logic             rs1_neg, rs2_neg;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0] result;

    always_comb begin
        rs1_signed = (op_i == INST_MULH) || (op_i == INST_MULHSU);
        rs2_signed = (op_i == INST_MULH);
        rs1_neg    = rs1_signed & multiplicand_i[WIDTH-1];
        rs2_neg    = rs2_signed & multiplier_i[WIDTH-1];

        addend   = mplier_reg[0] ? mcand_reg : '0;
        sum      = {1'b0, acc_hi_reg} + {1'b0, addend};

        prod_raw = {acc_hi_reg, mplier_reg};
        prod     = neg_reg ? -prod_raw : prod_raw;

        case (op_reg)
            INST_MUL:                           result = prod[WIDTH-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU: result = prod[2*WIDTH-1:WIDTH];
            default:                            result = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;
        mcand_next  = mcand_reg;
        acc_hi_next = acc_hi_reg;
        mplier_next = mplier_reg;
        data_next   = data_reg;
        ready_next  = 1'b0;

        if (!valid_i) begin
            // Abort: drop everything so no partial result is ever visible.
            state_next  = IDLE;
            count_next  = '0;
            op_next     = '0;
            neg_next    = 1'b0;
            mcand_next  = '0;
            acc_hi_next = '0;
            mplier_next = '0;
            data_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next  = CALC;
                    count_next  = CW'(WIDTH - 1);
                    op_next     = op_i;
                    neg_next    = rs1_neg ^ rs2_neg;
                    // The most negative value maps to 2^(WIDTH-1), still fits unsigned.
                    mcand_next  = rs1_neg ? -multiplicand_i : multiplicand_i;
                    mplier_next = rs2_neg ? -multiplier_i   : multiplier_i;
                    acc_hi_next = '0;
                    data_next   = '0;
                end
                CALC: begin
                    acc_hi_next = sum[WIDTH:1];
                    mplier_next = {sum[0], mplier_reg[WIDTH-1:1]};
                    count_next  = count_reg - CW'(1);
                    if (count_reg == '0) begin
                        state_next = END;
                    end
                end
                END: begin
                    data_next  = result;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            mcand_reg  <= '0;
            acc_hi_reg <= '0;
            mplier_reg <= '0;
            data_reg   <= '0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
            mcand_reg  <= mcand_next;
            acc_hi_reg <= acc_hi_next;
            mplier_reg <= mplier_next;
            data_reg   <= data_next;
            ready_reg  <= ready_next;
        end
    end

    assign data_o  = data_reg;
    assign ready_o = ready_reg;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: stimulus pushes expected results, a
// negedge monitor pops and compares on every ready_o pulse.
module tb_mul_iter;
    import tinyriscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [2:0]  op_i;
    logic [31:0] data_o;
    logic        ready_o;

    int compared   = 0;
    int mismatched = 0;
    int txn        = 0;
    bit mon_en     = 1'b1;
    logic [31:0] exp_q[$];

    mul_iter #(.WIDTH(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .op_i           (op_i),
        .data_o         (data_o),
        .ready_o        (ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint x, y;
        logic [63:0] p;
        x = (op == INST_MULH || op == INST_MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
        y = (op == INST_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
        p = x * y;
        case (op)
            INST_MUL:                           return p[31:0];
            INST_MULH, INST_MULHSU, INST_MULHU: return p[63:32];
            default:                            return 32'h0;
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (mon_en && rst_ni && ready_o) begin
            txn++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ready: got data %h, required no ready_o pulse", data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("result", data_o, e);
                $display("txn %0d: data_o=%h expected=%h", txn, data_o, e);
            end
        end
    end

    // Called on a negedge; returns on the negedge of the ready cycle (keep=1,
    // valid still high for a back-to-back start) or one idle cycle later.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit keep);
        int edges;
        op_i           = op;
        multiplicand_i = a;
        multiplier_i   = b;
        valid_i        = 1'b1;
        exp_q.push_back(exp);
        edges = 0;
        do begin
            @(posedge clk_i);
            edges++;
            #1;
        end while (!ready_o && edges < 100);
        check("latency", 32'(edges), 32'd34);
        @(negedge clk_i);
        if (!keep) begin
            valid_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    initial begin
        int edges;
        logic [31:0] a, b;
        logic [2:0]  op;

        rst_ni = 1'b0;
        valid_i = 1'b0;
        multiplicand_i = '0;
        multiplier_i = '0;
        op_i = INST_MUL;
        repeat (3) @(negedge clk_i);
        check("reset_ready", {31'b0, ready_o}, 32'h0);
        check("reset_data", data_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed vectors with hand-computed results.
        run_op(INST_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op(INST_MUL,    32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0);
        run_op(INST_MULH,   32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 1'b0);
        run_op(INST_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op(INST_MULH,   32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
        run_op(INST_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(INST_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 1'b0);
        run_op(INST_MULH,   32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 1'b0);
        run_op(3'b100,      32'h00000005, 32'h00000006, 32'h00000000, 1'b0);
        run_op(3'b111,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);

        // Back-to-back: valid stays high through the ready cycle.
        run_op(INST_MUL,    32'h00001234, 32'h00000010, 32'h00012340, 1'b1);
        run_op(INST_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op(INST_MUL,    32'h00000009, 32'h00000009, 32'h00000051, 1'b0);

        // Abort on the tenth CALC cycle: no pulse may follow.
        op_i = INST_MUL;
        multiplicand_i = 32'd7;
        multiplier_i = 32'd6;
        valid_i = 1'b1;
        repeat (11) @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("abort_ready", {31'b0, ready_o}, 32'h0);
        check("abort_data", data_o, 32'h0);
        run_op(INST_MUL, 32'd7, 32'd6, 32'd42, 1'b0);

        // Async reset while the result is presented.
        mon_en = 1'b0;
        op_i = INST_MULHU;
        multiplicand_i = 32'hFFFFFFFF;
        multiplier_i = 32'hFFFFFFFF;
        valid_i = 1'b1;
        edges = 0;
        do begin
            @(posedge clk_i);
            edges++;
            #1;
        end while (!ready_o && edges < 100);
        check("pre_reset_data", data_o, 32'hFFFFFFFE);
        #1 rst_ni = 1'b0;
        #1;
        check("async_reset_ready", {31'b0, ready_o}, 32'h0);
        check("async_reset_data", data_o, 32'h0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);

        // Async reset mid-CALC: no pulse afterwards, next op has full latency.
        op_i = INST_MULH;
        multiplicand_i = 32'h12345678;
        multiplier_i = 32'h9ABCDEF0;
        valid_i = 1'b1;
        repeat (15) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midcalc_reset_ready", {31'b0, ready_o}, 32'h0);
        check("midcalc_reset_data", data_o, 32'h0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk_i);
        run_op(INST_MULHSU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0);

        // Random operations against the 64-bit reference.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 3));
            case (i % 5)
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            b = (i % 7 == 0) ? 32'h80000000 : $urandom;
            run_op(op, a, b, model(op, a, b), (i % 3 == 0) && (i != 149));
        end

        repeat (5) @(negedge clk_i);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
